// File: rtl/handshake_const_match.sv
// Elastic consumer: compares accepted tokens against CONST_VALUE and returns one
// control token per input via a 2-slot match-bit FIFO. Optional: HANDSHAKE_CONST_MATCH_STICKY_ERR_EN.
module handshake_const_match #(
  parameter int          DATA_WIDTH  = 32,
  parameter int unsigned CONST_VALUE = 3,
  parameter int          CNT_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic                  outs_match,
  output logic [CNT_WIDTH-1:0]  mismatch_count
`ifdef HANDSHAKE_CONST_MATCH_STICKY_ERR_EN
  ,
  output logic                  err_sticky
`endif
);

  localparam logic [DATA_WIDTH-1:0] CONST_LO = DATA_WIDTH'(CONST_VALUE);
  localparam logic [CNT_WIDTH-1:0]  CNT_MAX  = {CNT_WIDTH{1'b1}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 head_q, head_d;
  logic                 tail_q, tail_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 err_q, err_d;
  logic                 in_xfer, out_xfer, match;

  // Ready depends only on registered state (and reset), never on outs_ready.
  assign ins_ready      = (state_q != FULL) && !rst;
  assign outs_valid     = (state_q != EMPTY);
  assign outs_match     = outs_valid && head_q;
  assign mismatch_count = cnt_q;

  assign match    = (ins == CONST_LO);
  assign in_xfer  = ins_valid && ins_ready;
  assign out_xfer = outs_valid && outs_ready;

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = ONE;
          head_d  = match;
        end
      end
      ONE: begin
        if (in_xfer && out_xfer) begin
          head_d = match;
        end else if (in_xfer) begin
          state_d = FULL;
          tail_d  = match;
        end else if (out_xfer) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        // Input is blocked here, so only a drain can happen; tail moves to head.
        if (out_xfer) begin
          state_d = ONE;
          head_d  = tail_q;
        end
      end
      default: state_d = EMPTY;
    endcase

    if (in_xfer && !match) begin
      err_d = 1'b1;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= 1'b0;
      tail_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

`ifdef HANDSHAKE_CONST_MATCH_STICKY_ERR_EN
  assign err_sticky = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif

endmodule
